// File: rtl/seq_logic_pkg.sv
// Shared definitions for the sequential bitwise logic unit.
//   state_e   : controller states (IDLE / BUSY / DONE), 2-bit encoding
//   op_e      : logic operation codes (AND / OR / XOR / NOR)
//   cnt_width : width of a counter that walks n slices (at least 1 bit)
package seq_logic_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  // A single-slice build still needs a 1-bit counter so the port widths stay legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slice_logic_op.sv
// Combinational logic operation on one slice of the operands.
// Ports:
//   op  : operation select (AND / OR / XOR / NOR)
//   a   : operand A slice, SLICE_W bits
//   b   : operand B slice, SLICE_W bits
//   y   : f(op, a, b), SLICE_W bits
module slice_logic_op
  import seq_logic_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  op_e                op,
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic [SLICE_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/seq_bitwise_logic_unit.sv
// Multi-cycle bitwise logic engine: applies AND / OR / XOR / NOR to two
// WIDTH-bit operands, SLICE_W bits per clock, with valid/ready handshakes on
// both sides. WIDTH must be a multiple of SLICE_W.
// Optional feature macro: SEQ_LOGIC_PARITY_EN adds a 'parity' output holding
// the XOR-reduction of the result, valid together with out_valid.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid / in_ready : operation handshake (op, input_a, input_b)
//   op                  : 00 AND, 01 OR, 10 XOR, 11 NOR
//   input_a, input_b    : operands, WIDTH bits
//   out_valid/out_ready : result handshake
//   result              : WIDTH-bit result, held until the next accept
//   zero                : result == 0, only asserted while out_valid
//   parity              : (SEQ_LOGIC_PARITY_EN only) ^result
module seq_bitwise_logic_unit
  import seq_logic_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef SEQ_LOGIC_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = cnt_width(NSLICE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  state_e                          state;
  state_e                          state_next;
  logic [CNT_W-1:0]                cnt;
  logic [NSLICE-1:0][SLICE_W-1:0]  a_reg;
  logic [NSLICE-1:0][SLICE_W-1:0]  b_reg;
  logic [NSLICE-1:0][SLICE_W-1:0]  res_reg;
  logic [NSLICE-1:0][SLICE_W-1:0]  res_next;
  op_e                             op_reg;
  logic                            zero_reg;
  logic                            parity_reg;
  logic [SLICE_W-1:0]              a_slice;
  logic [SLICE_W-1:0]              b_slice;
  logic [SLICE_W-1:0]              slice_res;
  logic                            accept;
  logic                            release_out;
  logic                            last_slice;

  assign accept      = in_valid && in_ready;
  assign release_out = out_valid && out_ready;
  assign last_slice  = (cnt == LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs. in_ready is masked by reset so that it
  // only rises once reset has been released.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = !reset;
        if (in_valid && !reset) state_next = S_BUSY;
      end
      S_BUSY: begin
        if (last_slice) state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Select the current operand slices with constant indices so that
  // non-power-of-two slice counts never index past the arrays.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt == CNT_W'(i)) begin
        a_slice = a_reg[i];
        b_slice = b_reg[i];
      end
    end
  end

  slice_logic_op #(
    .SLICE_W(SLICE_W)
  ) u_slice_op (
    .op(op_reg),
    .a (a_slice),
    .b (b_slice),
    .y (slice_res)
  );

  // Result as it will look after this cycle's slice write; zero is taken from
  // this so it reflects the complete result on the edge that enters DONE.
  always_comb begin
    res_next = res_reg;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt == CNT_W'(i)) res_next[i] = slice_res;
    end
  end

  // Datapath registers. The counter parks on the last slice rather than
  // wrapping; the next accept reloads it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= OP_AND;
      res_reg    <= '0;
      zero_reg   <= 1'b0;
      parity_reg <= 1'b0;
    end else if (accept) begin
      cnt        <= '0;
      a_reg      <= input_a;
      b_reg      <= input_b;
      op_reg     <= op_e'(op);
      res_reg    <= '0;
      zero_reg   <= 1'b0;
      parity_reg <= 1'b0;
    end else if (state == S_BUSY) begin
      res_reg    <= res_next;
      parity_reg <= parity_reg ^ (^slice_res);
      if (last_slice) begin
        zero_reg <= ~|res_next;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (release_out) begin
      zero_reg <= 1'b0;
    end
  end

  assign result = res_reg;
  assign zero   = zero_reg;

`ifdef SEQ_LOGIC_PARITY_EN
  assign parity = parity_reg;
`else
  logic unused_parity;
  assign unused_parity = parity_reg;
`endif

endmodule

// File: tb/tb_seq_bitwise_logic_unit.sv
// Self-checking bench for seq_bitwise_logic_unit: a 32/8 instance and a
// single-slice 16/16 instance, each with an expected-result queue filled on
// stimulus and drained by a monitor when the DUT presents a result.
module tb_seq_bitwise_logic_unit;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        par;
  } exp_t;

  logic        clk;
  logic        reset;

  logic        in_valid, in_ready, out_valid, out_ready, zero;
  logic [1:0]  op_s;
  logic [31:0] input_a, input_b, result;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_zero;
  logic [1:0]  s_op;
  logic [15:0] s_a, s_b, s_result;

`ifdef SEQ_LOGIC_PARITY_EN
  logic        parity, s_parity;
`endif

  exp_t q_main[$];
  exp_t q_single[$];
  int   vector_count = 0;
  int   miscompare_count = 0;
  int   cycle_cnt = 0;
  int   accept_cycle = 0;

  seq_bitwise_logic_unit #(.WIDTH(32), .SLICE_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .op(op_s),
    .input_a(input_a), .input_b(input_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
`ifdef SEQ_LOGIC_PARITY_EN
    , .parity(parity)
`endif
  );

  seq_bitwise_logic_unit #(.WIDTH(16), .SLICE_W(16)) dut_single (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
    .input_a(s_a), .input_b(s_b),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .result(s_result), .zero(s_zero)
`ifdef SEQ_LOGIC_PARITY_EN
    , .parity(s_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic logic [31:0] model_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  // Drive one operation into the 32-bit unit; returns #1 after the accept edge.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", in_ready, 1);
    op_s = o; input_a = a; input_b = b; in_valid = 1'b1;
    if (push) begin
      e.res  = model_op(o, a, b);
      e.zero = (e.res == 32'h0);
      e.par  = ^e.res;
      q_main.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    accept_cycle = cycle_cnt;
  endtask

  task automatic applySingleStimulus(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [31:0] full;
    int          waited = 0;
    @(negedge clk);
    while (!s_in_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!s_in_ready) checkOutput("s_in_ready_timeout", s_in_ready, 1);
    s_op = o; s_a = a; s_b = b; s_in_valid = 1'b1;
    full   = model_op(o, {16'h0, a}, {16'h0, b});
    e.res  = {16'h0, full[15:0]};
    e.zero = (full[15:0] == 16'h0);
    e.par  = ^full[15:0];
    q_single.push_back(e);
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    accept_cycle = cycle_cnt;
  endtask

  task automatic drainQueues();
    int n = 0;
    while ((q_main.size() != 0 || q_single.size() != 0) && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q_main.size() != 0) checkOutput("drain_main", q_main.size(), 0);
    if (q_single.size() != 0) checkOutput("drain_single", q_single.size(), 0);
  endtask

  // Scoreboard monitors: compare when a result handshake is about to happen.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (q_main.size() == 0) begin
        checkOutput("spurious_out", out_valid, 0);
      end else begin
        e = q_main.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("zero", zero, e.zero);
`ifdef SEQ_LOGIC_PARITY_EN
        checkOutput("parity", parity, e.par);
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && s_out_valid && s_out_ready) begin
      if (q_single.size() == 0) begin
        checkOutput("s_spurious_out", s_out_valid, 0);
      end else begin
        e = q_single.pop_front();
        checkOutput("s_result", s_result, e.res);
        checkOutput("s_zero", s_zero, e.zero);
`ifdef SEQ_LOGIC_PARITY_EN
        checkOutput("s_parity", s_parity, e.par);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int first_acc;
    int n;
    reset = 1'b1;
    in_valid = 1'b0; op_s = 2'b00; input_a = '0; input_b = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_op = 2'b00; s_a = '0; s_b = '0; s_out_ready = 1'b1;

    // Reset state.
    #12;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_zero", zero, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_s_result", s_result, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("in_ready_after_rst", in_ready, 1);

    // XOR with latency check.
    applyStimulus(2'b10, 32'hFFFF0000, 32'h0F0F0F0F, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("xor_lat_busy", out_valid, 0);
    end
    @(posedge clk);
    #1;
    checkOutput("xor_lat_done", out_valid, 1);
    drainQueues();
    checkOutput("xor_result_retained", result, 32'hF0F00F0F);
    checkOutput("xor_in_ready_idle", in_ready, 1);

    // AND to zero, then zero must drop once the result is consumed.
    applyStimulus(2'b00, 32'h12345678, 32'h00000000, 1);
    drainQueues();
    checkOutput("zero_after_release", zero, 0);
    checkOutput("out_valid_after_release", out_valid, 0);

    // NOR of zeros, plus OR/XOR patterns.
    applyStimulus(2'b11, 32'h0, 32'h0, 1);
    applyStimulus(2'b01, 32'h80000001, 32'h00FF0000, 1);
    applyStimulus(2'b10, 32'hCAFEBABE, 32'hCAFEBABE, 1);
    drainQueues();

    // Backpressure: hold the result in DONE while the inputs churn.
    out_ready = 1'b0;
    applyStimulus(2'b00, 32'hDEADBEEF, 32'hFF00FF00, 1);
    n = 0;
    while (!out_valid && n < 32) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("bp_reach_done", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      input_a = $urandom;
      in_valid = 1'b1;
      @(negedge clk);
      checkOutput("bp_result", result, 32'hDE00BE00);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_out_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_in_ready_after", in_ready, 1);
    drainQueues();

    // Reset in the middle of an operation.
    applyStimulus(2'b10, 32'hFFFFFFFF, 32'h00000000, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("partial_result", result, 32'h0000FFFF);
    reset = 1'b1;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_result", result, 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(2'b01, 32'hA5A5A5A5, 32'h5A5A5A5A, 1);
    drainQueues();

`ifdef SEQ_LOGIC_PARITY_EN
    applyStimulus(2'b10, 32'h00000007, 32'h0, 1);
    applyStimulus(2'b10, 32'h00000003, 32'h0, 1);
    drainQueues();
`endif

    // Single-slice instance: one-cycle latency and back-to-back period.
    applySingleStimulus(2'b10, 16'h00FF, 16'hFFFF);
    @(posedge clk);
    #1;
    checkOutput("single_lat", s_out_valid, 1);
    applySingleStimulus(2'b00, 16'h1234, 16'hFF0F);
    first_acc = accept_cycle;
    applySingleStimulus(2'b11, 16'h0F0F, 16'hF0F0);
    checkOutput("single_b2b_period", accept_cycle - first_acc, 3);
    drainQueues();

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule
